fifo_wr_arbiter: RTL
====================

# fifo_wr_arbiter

Round-robin write arbiter that shares one FIFO write port between NREQ producers. Grants the port to one requester at a time for a bounded burst, drives the FIFO's write-enable and write data, and returns per-word acknowledges. Sits directly in front of the FIFO's `w_en`/`data_in` and observes its `full` flag.

## Interface
- One clock; reset is asynchronous and active-low.

Parameters:
- `WIDTH`, 2, data word width; matches the FIFO data width.
- `NREQ`, 4, number of requesters (≥2).
- `BURST`, 4, maximum words accepted per grant (≥1).
- `TIMEOUT`, 16, full-stall cycles before a forced release. Used only with `FIFO_ARB_TIMEOUT_EN`.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous active-low reset.
- `req`  in  NREQ  requester i has a word to write.
- `req_last`  in  NREQ  the current word of requester i is its last.
- `req_data`  in  NREQ*WIDTH  word of requester i on `[i*WIDTH +: WIDTH]`.
- `gnt`  out  NREQ  one-hot registered owner; all-zero when idle.
- `ack`  out  NREQ  word of requester i accepted this cycle.
- `fifo_full`  in  1  FIFO full flag.
- `fifo_w_en`  out  1  FIFO write enable.
- `fifo_data`  out  WIDTH  FIFO write data.
- `stall`  out  1  one-cycle pulse on timeout release.

## Operation
- **FSM states:** IDLE, BURST.
- **IDLE:**
  - `gnt`=0.
  - If any `req` bit is set, select the first set bit searching from `last_owner+1` upward, wrapping modulo NREQ.
  - Register the selected bit into `gnt`, record it as `owner` and `last_owner`, clear `word_cnt`, and go to BURST.
- **BURST:**
  - `fifo_w_en = req[owner] & ~fifo_full`. This is combinational from the registered `gnt`.
  - `fifo_data = req_data[owner]` while in BURST; 0 otherwise.
  - `ack = gnt` when `fifo_w_en`=1, else 0. Only `ack[owner]` can be 1.
  - Each accepted word increments `word_cnt`.
- **Release (BURST→IDLE, `gnt` cleared next cycle)** occurs on the first of:
  - a word accepted with `req_last[owner]`=1;
  - a word accepted with `word_cnt` == BURST-1;
  - `req[owner]`=0 (owner abandons, nothing written that cycle);
  - a timeout, when the macro is enabled.
- **Full FIFO:** while `fifo_full`=1 the owner keeps the grant and nothing is written. `word_cnt` does not advance.
- **Fairness:** `last_owner` is updated only on grant. A requester that releases is searched last in the next arbitration.
- **Width rules:**
  - `word_cnt` is $clog2(BURST+1) bits.
  - The timeout counter is $clog2(TIMEOUT+1) bits and saturates.
- **Reset values:**
  - state IDLE;
  - `gnt`=0, `ack`=0, `fifo_w_en`=0, `fifo_data`=0, `stall`=0;
  - `word_cnt`=0;
  - `last_owner`=NREQ-1, so requester 0 wins first.
- **Reset mid-burst:** all outputs go to their reset values asynchronously. No partial word is written after `rst` falls.

## Timing
- **Grant latency:** `req` sampled high in IDLE at edge n gives `gnt` high after edge n. The first write can occur in that same cycle if not full.
- **Throughput:** one word per cycle during a burst.
- **Bubble:** exactly one idle cycle (`gnt`=0) between consecutive bursts.
- **Last word:** the last accepted word and the release decision happen in the same cycle. `gnt` drops at the following edge.
- **Handshake:** a requester must hold `req`/`req_data` stable until it sees `ack`. It advances to its next word on the cycle after `ack`.
- **Simultaneous events:** `req_last` with a full FIFO does not release; the word is not yet accepted.

## Configuration
- Macro: `FIFO_ARB_TIMEOUT_EN`.
- **Defined:**
  - In BURST, a counter increments each cycle with `req[owner] & fifo_full`. It clears on any accepted word and on grant.
  - When the count reaches TIMEOUT, the burst releases. `stall` pulses high for the cycle in which the release is decided. `last_owner` stays, so the owner is searched last.
- **Undefined:** no timeout counter. `stall` is tied 0. The owner waits on a full FIFO indefinitely.

## Test plan
- **Reset defaults:** `rst`=0 → `gnt`=0000, `ack`=0000, `fifo_w_en`=0, `stall`=0. With `req`=1111 after reset, the first grant is `gnt`=0001.
- **Round-robin rotation:**
  - Stimulus: `req`=1111 held, `req_last`=0, BURST=4, FIFO never full.
  - Response: four writes each for owners 0,1,2,3, then 0 again, with a 1-cycle `gnt`=0 bubble between bursts.
- **Early last:**
  - Stimulus: requester 2 alone, data 2'b01 then 2'b10 with `req_last` on the second word.
  - Response: exactly two `fifo_w_en` pulses with `fifo_data` 01 then 10, and `gnt` drops after the second.
- **Full backpressure:**
  - Stimulus: owner 1 granted, `fifo_full`=1 for 5 cycles, then 0.
  - Response: `fifo_w_en`=0 and `ack`=0 for 5 cycles, `gnt` held at 0010, writes resume on the cycle `fifo_full` falls.
- **Timeout (macro defined, TIMEOUT=16):**
  - Stimulus: owner 0 with `fifo_full` stuck at 1.
  - Response: `stall`=1 for one cycle after 16 stalled cycles. Next grant goes to requester 1 if `req[1]`=1. Without the macro, `gnt` stays 0001.
- **Reset mid-burst:**
  - Stimulus: assert `rst` low asynchronously during owner 3's second word.
  - Response: `fifo_w_en` and `gnt` go 0 immediately. After release of reset, requester 0 is favored.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// Requester/FIFO-side bundle for fifo_wr_arbiter.
// master: producers plus FIFO status (the environment); slave: the arbiter.
interface fifo_wr_arbiter_if #(
    parameter int WIDTH = 2,
    parameter int NREQ  = 4
);
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       req_last;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       ack;
    logic                  fifo_full;
    logic                  fifo_w_en;
    logic [WIDTH-1:0]      fifo_data;
    logic                  stall;

    modport master (
        output req, req_last, req_data, fifo_full,
        input  gnt, ack, fifo_w_en, fifo_data, stall
    );

    modport slave (
        input  req, req_last, req_data, fifo_full,
        output gnt, ack, fifo_w_en, fifo_data, stall
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NREQ producers.
// A grant lasts for at most BURST accepted words. It ends early on req_last
// or when the owner drops req.
// Optional feature macro: FIFO_ARB_TIMEOUT_EN. When it is defined, a burst is
// force-released after TIMEOUT consecutive full-stalled cycles, and stall
// pulses for that release.
module fifo_wr_arbiter #(
    parameter int WIDTH   = 2,
    parameter int NREQ    = 4,
    parameter int BURST   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,   // asynchronous, active low
    fifo_wr_arbiter_if.slave bus
);
    localparam int IDXW = $clog2(NREQ);
    localparam int CNTW = $clog2(BURST + 1);

    typedef enum logic {S_IDLE, S_BURST} state_t;

    state_t             state_q, state_d;
    logic [NREQ-1:0]    gnt_q, gnt_d;
    logic [IDXW-1:0]    owner_q, owner_d;
    logic [IDXW-1:0]    last_owner_q, last_owner_d;
    logic [CNTW-1:0]    word_cnt_q, word_cnt_d;

    logic               pick_valid;
    logic [IDXW-1:0]    pick_idx;
    logic               in_burst;
    logic               owner_req;
    logic               owner_last;
    logic [WIDTH-1:0]   owner_data;
    logic               w_en;
    logic               last_hit;
    logic               timeout_hit;
    logic               release_burst;

    assign in_burst   = (state_q == S_BURST);
    assign owner_req  = bus.req[owner_q];
    assign owner_last = bus.req_last[owner_q];
    assign owner_data = bus.req_data[owner_q*WIDTH +: WIDTH];
    assign w_en       = in_burst & owner_req & ~bus.fifo_full;
    assign last_hit   = w_en & (owner_last | (word_cnt_q == CNTW'(BURST - 1)));

`ifdef FIFO_ARB_TIMEOUT_EN
    localparam int TMOW = $clog2(TIMEOUT + 1);
    logic [TMOW-1:0] tmo_cnt_q, tmo_cnt_d;

    assign timeout_hit = in_burst & (tmo_cnt_q == TMOW'(TIMEOUT));

    // Full-stall counter: counts stalled cycles of the owner, saturating
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (!in_burst || w_en) begin
            tmo_cnt_d = '0;
        end else if (owner_req && bus.fifo_full && tmo_cnt_q != TMOW'(TIMEOUT)) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    // Stall counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) tmo_cnt_q <= '0;
        else      tmo_cnt_q <= tmo_cnt_d;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    assign release_burst = in_burst & (last_hit | ~owner_req | timeout_hit);

    // Round-robin pick: first set req bit after last_owner, wrapping
    always_comb begin
        int cand;
        cand       = 0;
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(last_owner_q) + k) % NREQ;
            if (!pick_valid && bus.req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = IDXW'(cand);
            end
        end
    end

    // State register; everything returns to idle values on reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            gnt_q        <= '0;
            owner_q      <= '0;
            last_owner_q <= IDXW'(NREQ - 1);
            word_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            word_cnt_q   <= word_cnt_d;
        end
    end

    // Next-state: grant in IDLE, count words and decide release in BURST
    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        word_cnt_d   = word_cnt_q;
        case (state_q)
            S_IDLE: begin
                gnt_d = '0;
                if (pick_valid) begin
                    state_d      = S_BURST;
                    gnt_d        = NREQ'(1) << pick_idx;
                    owner_d      = pick_idx;
                    last_owner_d = pick_idx;
                    word_cnt_d   = '0;
                end
            end
            S_BURST: begin
                if (w_en) word_cnt_d = word_cnt_q + 1'b1;
                if (release_burst) begin
                    state_d = S_IDLE;
                    gnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // Outputs: the write path is combinational off the registered grant
    always_comb begin
        bus.gnt       = gnt_q;
        bus.fifo_w_en = w_en;
        bus.ack       = w_en ? gnt_q : '0;
        bus.fifo_data = in_burst ? owner_data : '0;
        bus.stall     = timeout_hit;
    end
endmodule
